// File: rtl/ghostchip_pkg.sv
// Shared definitions for the keypad front end and its consumers.
package ghostchip_pkg;

  // One hex key code; the CPU uses the same type for key operands.
  typedef logic [3:0] key_code_t;

  // Number of pending key presses the event queue can hold.
  localparam int KEY_FIFO_DEPTH = 4;

  // Physical index p = col*4 + row  ->  CHIP-8 key code.
  // Keypad face, rows top to bottom: 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F.
  localparam key_code_t KEYMAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'hA,   // column 0, rows 0..3
    4'h2, 4'h5, 4'h8, 4'h0,   // column 1
    4'h3, 4'h6, 4'h9, 4'hB,   // column 2
    4'hC, 4'hD, 4'hE, 4'hF    // column 3
  };

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic key_code_t lowestSet(input logic [15:0] bits);
    key_code_t code;
    code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) code = key_code_t'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake between the keypad scanner and its consumer.
interface keypad_scanner_if;
  import ghostchip_pkg::*;

  logic      key_valid;
  key_code_t key_code;
  logic      key_ready;

  // The scanner produces events.
  modport master (output key_valid, output key_code, input key_ready);

  // The CPU consumes events.
  modport slave (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/key_fifo.sv
// Small first-word-fall-through queue of key codes. The head entry is
// always visible on o_data; a pop while empty is ignored, and a push
// while full is accepted only if a pop frees the slot in the same cycle.
module key_fifo
  import ghostchip_pkg::*;
#(
  parameter int DEPTH = KEY_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  key_code_t i_data,
  input  logic      i_pop,
  output key_code_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  key_code_t     r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic w_doPop;
  logic w_doPush;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Storage, pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= nextPtr(r_wrPtr);
      end
      if (w_doPop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 hex keypad, debounces each key once per frame, exposes the
// debounced level of all 16 keys and queues a code for every new press.
module keypad_scanner
  import ghostchip_pkg::*;
#(
  parameter int SCAN_DIV = 12000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  output logic [15:0] matrix,
  keypad_scanner_if.master key_if
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LIMIT  = CW'(DEBOUNCE);

  // Scan state.
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [3:0]    r_colOut;
  logic [15:0]   r_raw;

  // Debounce state: stable levels indexed by key code, counters by physical key.
  logic [15:0]   r_stable;
  logic [CW-1:0] r_cnt [16];
  logic [15:0]   r_pending;

  logic          w_sample;
  logic          w_frameEnd;
  logic [15:0]   w_rawFrame;
  logic [15:0]   w_stableNext;
  logic [CW-1:0] w_cntNext [16];
  logic [15:0]   w_rise;
  key_code_t     w_pushCode;
  logic          w_push;
  logic [15:0]   w_clear;
  logic          w_pop;
  logic          w_fifoFull;
  logic          w_fifoEmpty;
  key_code_t     w_fifoData;

  assign w_sample   = (r_dwell == DWELL_LAST);
  assign w_frameEnd = w_sample && (r_col == 2'd3);
  assign w_pop      = key_if.key_ready && !w_fifoEmpty;

  // Column dwell counter and row sampling; the column drive is registered so it switches together with the column index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell  <= '0;
      r_col    <= 2'd0;
      r_colOut <= 4'b1110;
      r_raw    <= '0;
    end else if (w_sample) begin
      r_dwell                   <= '0;
      r_col                     <= r_col + 2'd1;
      r_colOut                  <= ~(4'b0001 << (r_col + 2'd1));
      r_raw[{r_col, 2'b00} +: 4] <= ~row_in;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Frame-end debounce: column 3 is taken straight from the pins so the whole frame is judged on the sample edge itself.
  always_comb begin
    w_rawFrame   = {~row_in, r_raw[11:0]};
    w_stableNext = r_stable;
    w_rise       = '0;
    for (int p = 0; p < 16; p++) begin
      w_cntNext[p] = r_cnt[p];
    end
    if (w_frameEnd) begin
      for (int p = 0; p < 16; p++) begin
        if (w_rawFrame[p] == r_stable[KEYMAP[p]]) begin
          w_cntNext[p] = '0;
        end else if ((r_cnt[p] + CW'(1)) == CNT_LIMIT) begin
          w_cntNext[p]              = '0;
          w_stableNext[KEYMAP[p]]   = w_rawFrame[p];
          w_rise[KEYMAP[p]]         = w_rawFrame[p];
        end else begin
          w_cntNext[p] = r_cnt[p] + CW'(1);
        end
      end
    end
  end

  // Debounced levels and per-key disagreement counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int p = 0; p < 16; p++) r_cnt[p] <= '0;
    end else begin
      r_stable <= w_stableNext;
      for (int p = 0; p < 16; p++) r_cnt[p] <= w_cntNext[p];
    end
  end

  // Lowest pending code enters the queue; a slot freed by a pop this cycle counts as room.
  always_comb begin
    w_pushCode = lowestSet(r_pending);
    w_push     = (r_pending != '0) && (!w_fifoFull || w_pop);
    w_clear    = w_push ? (16'd1 << w_pushCode) : 16'd0;
  end

  // Pending presses; a press that lands on a code still waiting simply stays set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_rise;
    end
  end

  key_fifo #(
    .DEPTH (KEY_FIFO_DEPTH)
  ) u_keyFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_pushCode),
    .i_pop   (key_if.key_ready),
    .o_data  (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign col_out          = r_colOut;
  assign matrix           = r_stable;
  assign key_if.key_valid = !w_fifoEmpty;
  assign key_if.key_code  = w_fifoData;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a short scan period: a keypad model drives
// the rows, directed presses push expected codes into a scoreboard, and a
// monitor pops and compares whenever the DUT hands over an event.
module tb_keypad_scanner;
  import ghostchip_pkg::*;

  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic [15:0] matrix;
  logic [15:0] keysPhys;

  keypad_scanner_if keyBus();

  int        checks   = 0;
  int        failures = 0;
  int        cyc      = 0;
  key_code_t sbQueue [$];
  key_code_t expCode;

  localparam logic [3:0] COL_SEQ [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_out (col_out),
    .row_in  (row_in),
    .matrix  (matrix),
    .key_if  (keyBus)
  );

  // Passive matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_out[c] && keysPhys[c*4 + r]) row_in[r] = 1'b0;
      end
    end
  end

  // Cycle index since the last reset release.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: every handed-over event must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && keyBus.key_valid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event: got code %h, required no event", keyBus.key_code);
      end else if (keyBus.key_ready === 1'b1) begin
        expCode = sbQueue.pop_front();
        checks++;
        if (keyBus.key_code !== expCode) begin
          failures++;
          $display("[TB] FAIL event_order: got code %h, required %h", keyBus.key_code, expCode);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input logic ready);
    keysPhys         = keys;
    keyBus.key_ready = ready;
  endtask

  task automatic waitUntilCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values and column rotation.
    checkOutput("reset_col_out", 16'(col_out), 16'h000E);
    checkOutput("reset_matrix", matrix, 16'h0000);
    checkOutput("reset_valid", 16'(keyBus.key_valid), 16'h0000);
    checkOutput("reset_code", 16'(keyBus.key_code), 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      waitUntilCycle(8 * i);
      checkOutput("col_rotation", 16'(col_out), 16'(COL_SEQ[i-1]));
    end

    // Single press of the column-0/row-0 key (code 1).
    applyStimulus(16'h0001, 1'b0);
    sbQueue.push_back(4'h1);
    waitUntilCycle(127);
    checkOutput("press_before_flip", matrix, 16'h0000);
    waitUntilCycle(128);
    checkOutput("press_matrix", matrix, 16'h0002);
    checkOutput("press_valid_late", 16'(keyBus.key_valid), 16'h0000);
    waitUntilCycle(129);
    checkOutput("press_valid", 16'(keyBus.key_valid), 16'h0001);
    checkOutput("press_code", 16'(keyBus.key_code), 16'h0001);
    applyStimulus(16'h0001, 1'b1);
    waitUntilCycle(130);
    checkOutput("pop_empty", 16'(keyBus.key_valid), 16'h0000);

    // Release of the held key clears the bit three frames later, no event.
    applyStimulus(16'h0000, 1'b0);
    waitUntilCycle(223);
    checkOutput("release_hold", matrix, 16'h0002);
    waitUntilCycle(224);
    checkOutput("release_clear", matrix, 16'h0000);

    // Bounce: two agreeing frames only.
    applyStimulus(16'h0001, 1'b0);
    waitUntilCycle(226);
    checkOutput("release_no_event", 16'(keyBus.key_valid), 16'h0000);
    waitUntilCycle(288);
    checkOutput("bounce_mid", matrix, 16'h0000);
    applyStimulus(16'h0000, 1'b0);
    waitUntilCycle(320);
    checkOutput("bounce_matrix", matrix, 16'h0000);
    checkOutput("bounce_valid", 16'(keyBus.key_valid), 16'h0000);

    // Overflow: codes 0,3,7,A,F pressed together (physical 7,8,2,3,15).
    applyStimulus(16'h818C, 1'b0);
    sbQueue.push_back(4'h0);
    sbQueue.push_back(4'h3);
    sbQueue.push_back(4'h7);
    sbQueue.push_back(4'hA);
    sbQueue.push_back(4'hF);
    waitUntilCycle(416);
    checkOutput("multi_matrix", matrix, 16'h8489);
    checkOutput("multi_valid_late", 16'(keyBus.key_valid), 16'h0000);
    waitUntilCycle(417);
    checkOutput("multi_head", 16'(keyBus.key_code), 16'h0000);
    waitUntilCycle(421);
    checkOutput("full_valid", 16'(keyBus.key_valid), 16'h0001);
    checkOutput("full_head", 16'(keyBus.key_code), 16'h0000);
    applyStimulus(16'h818C, 1'b1);
    waitUntilCycle(422);
    applyStimulus(16'h818C, 1'b0);
    checkOutput("after_pop_valid", 16'(keyBus.key_valid), 16'h0001);
    checkOutput("after_pop_head", 16'(keyBus.key_code), 16'h0003);
    waitUntilCycle(423);
    applyStimulus(16'h818C, 1'b1);
    waitUntilCycle(427);
    applyStimulus(16'h818C, 1'b0);
    checkOutput("drain_valid", 16'(keyBus.key_valid), 16'h0000);
    checkOutput("drain_count", 16'(sbQueue.size()), 16'h0000);

    // Mid-frame reset with keys held.
    waitUntilCycle(461);
    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midreset_col_out", 16'(col_out), 16'h000E);
    checkOutput("midreset_matrix", matrix, 16'h0000);
    checkOutput("midreset_valid", 16'(keyBus.key_valid), 16'h0000);
    checkOutput("midreset_code", 16'(keyBus.key_code), 16'h0000);
    rst_n = 1'b1;
    waitUntilCycle(8);
    checkOutput("midreset_restart", 16'(col_out), 16'h000D);
    waitUntilCycle(128);
    checkOutput("midreset_quiet_matrix", matrix, 16'h0000);
    checkOutput("midreset_quiet_valid", 16'(keyBus.key_valid), 16'h0000);

    // Push and pop in the same cycle: code 1 waits, code 2 arrives one frame later.
    applyStimulus(16'h0001, 1'b0);
    sbQueue.push_back(4'h1);
    waitUntilCycle(160);
    applyStimulus(16'h0011, 1'b0);
    sbQueue.push_back(4'h2);
    waitUntilCycle(225);
    checkOutput("hold_valid", 16'(keyBus.key_valid), 16'h0001);
    checkOutput("hold_code", 16'(keyBus.key_code), 16'h0001);
    waitUntilCycle(256);
    checkOutput("both_matrix", matrix, 16'h0006);
    checkOutput("swap_head_first", 16'(keyBus.key_code), 16'h0001);
    applyStimulus(16'h0011, 1'b1);
    waitUntilCycle(257);
    checkOutput("swap_valid", 16'(keyBus.key_valid), 16'h0001);
    checkOutput("swap_head_second", 16'(keyBus.key_code), 16'h0002);
    waitUntilCycle(258);
    checkOutput("swap_drained", 16'(keyBus.key_valid), 16'h0000);
    waitUntilCycle(262);
    checkOutput("final_scoreboard", 16'(sbQueue.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
